// File: rtl/pipe_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
// Optional feature macro used by ex_mem_stage: EX_MEM_STALL_CNT_EN.
package pipe_pkg;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ex_mem_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

    localparam int STALL_CNT_W = 32;
    localparam int CTRL_W      = $bits(ex_mem_ctrl_t);

endpackage

// File: rtl/pipe_slot.sv
// Payload register with load enable; clears to zero on reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    // Capture the payload only when loaded; otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer. The main slot drives the outputs; the skid slot catches a beat
// accepted while the main slot is stalled, so in_ready is a plain register.
// Optional feature macro: EX_MEM_STALL_CNT_EN adds a saturating stall_cnt.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_regwrite,
    input  logic            in_memtoreg,
    input  logic            in_memwrite,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_data,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_regwrite,
    output logic            out_memtoreg,
    output logic            out_memwrite,
    output logic [XLEN-1:0] out_alu,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int PW = CTRL_W + 2 * XLEN + RD_W;

    stage_state_t state_reg;
    stage_state_t state_next;
    logic         in_ready_reg;
    logic         in_ready_next;

    logic         in_fire;
    logic         out_fire;
    logic         main_load;
    logic         skid_load;
    logic         main_from_skid;

    ex_mem_ctrl_t in_ctrl;
    ex_mem_ctrl_t main_ctrl;
    logic [CTRL_W-1:0] ctrl_masked;

    logic [PW-1:0] in_beat;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    assign in_ctrl  = '{regwrite: in_regwrite, memtoreg: in_memtoreg, memwrite: in_memwrite};
    assign in_beat  = {in_ctrl, in_alu, in_data, in_rd};

    // Gate the registered ready with reset so it reads 0 while reset is held.
    assign in_ready  = in_ready_reg & reset;
    assign out_valid = (state_reg != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // State and registered in_ready; ready only depends on the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // Next-state and slot-load decisions; flush overrides everything.
    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    state_next = FULL;
                    main_load  = 1'b1;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    state_next = SKID;
                    skid_load  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    state_next     = FULL;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        if (flush) begin
            // Payloads are left untouched; only occupancy is cleared.
            state_next     = EMPTY;
            main_load      = 1'b0;
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
        end
        in_ready_next = (state_next != SKID);
    end

    assign main_d = main_from_skid ? skid_q : in_beat;

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_beat),
        .q     (skid_q)
    );

    assign main_ctrl = main_q[PW-1 -: CTRL_W];
    assign out_alu   = main_q[2*XLEN+RD_W-1 -: XLEN];
    assign out_data  = main_q[XLEN+RD_W-1 -: XLEN];
    assign out_rd    = main_q[RD_W-1:0];

    // Bubbles must never write, so every control bit is qualified by valid.
    generate
        for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign ctrl_masked[gi] = main_ctrl[gi] & out_valid;
        end
    endgenerate

    assign out_regwrite = ctrl_masked[2];
    assign out_memtoreg = ctrl_masked[1];
    assign out_memwrite = ctrl_masked[0];

`ifdef EX_MEM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    // Saturating count of cycles where a beat waits on MEM; flush does not clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised successor of the fixed EX/MEM pipeline register.
- Carries the same control bits (RegWrite, MemtoReg, MemWrite) plus ALU result, store data and destination register.
- Adds a valid/ready handshake, a 2-entry skid buffer so stalls do not combinationally cross stages, synchronous flush, and bubble control masking.
- Sits between the EX stage and data memory.

Parameters:
- XLEN, 64, width of ALU result and store data
- RD_W, 5, width of destination register index

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset; asynchronous, active-low (0 = reset asserted)
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EX presents a beat
- in_ready  out  1  stage can accept a beat
- in_regwrite  in  1  control: register-file write
- in_memtoreg  in  1  control: writeback selects memory
- in_memwrite  in  1  control: memory write
- in_alu  in  XLEN  ALU result
- in_data  in  XLEN  store data
- in_rd  in  RD_W  destination register
- out_valid  out  1  MEM beat present
- out_ready  in  1  MEM accepts the beat
- out_regwrite, out_memtoreg, out_memwrite  out  1 each  control, masked
- out_alu  out  XLEN  ALU result
- out_data  out  XLEN  store data
- out_rd  out  RD_W  destination register

Behaviour:
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main slot drives all outputs; skid slot catches a beat accepted while main is stalled.
- FSM states: EMPTY (no entry), FULL (main valid), SKID (main and skid valid).
- EMPTY:
  - in_fire -> FULL, main <= inputs.
  - Latency is 1 cycle input to output.
- FULL:
  - in_fire & out_fire -> FULL, main <= inputs.
  - in_fire & !out_ready -> SKID, skid <= inputs.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- SKID:
  - out_fire -> FULL, main <= skid.
  - Otherwise hold.
- in_ready is a register: 1 in EMPTY/FULL, 0 in SKID. No combinational path from out_ready to in_ready.
- out_valid = 1 in FULL or SKID.
- Control masking: out_regwrite/out_memtoreg/out_memwrite = stored bit AND out_valid, so bubbles never write.
- Data outputs: hold their last value when invalid. They change only on a main-slot load.
- Flush:
  - Synchronous; highest priority.
  - Next state EMPTY; any beat fired in the flush cycle is discarded.
  - Payload registers keep their values; only the valids clear.
- Reset (reset=0, async, including mid-operation):
  - State EMPTY; in_ready=1 after reset deasserts (0 while asserted).
  - out_valid=0; all control outputs 0; out_alu=0, out_data=0, out_rd=0; skid payload 0.
- Ordering: beats exit in acceptance order; no beat is duplicated or dropped except by flush.
- Holding: in_* may change freely when in_fire=0; outputs are stable while out_valid & !out_ready.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (out, 32) counting cycles with out_valid=1 & out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only, not by flush.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package pipe_pkg:
  - typedef ex_mem_ctrl_t (packed struct: regwrite, memtoreg, memwrite).
  - typedef stage_state_t enum {EMPTY, FULL, SKID}.
  - Constant STALL_CNT_W = 32.
- Sub-module pipe_slot: parametrised payload register with load enable and async active-low reset to zero. Instantiated twice (main, skid).

Test Plan:
- Reset then single beat: in_alu=64'h1234, in_rd=5'd7, in_regwrite=1, out_ready=1 -> next cycle out_valid=1, out_alu=64'h1234, out_rd=7, out_regwrite=1; following cycle out_valid=0, out_regwrite=0.
- Back-to-back streaming: 8 beats, in_alu=0..7, out_ready=1 -> outputs 0..7 on consecutive cycles; in_ready stays 1.
- Stall into skid: out_ready=0, send beats A=64'hA, B=64'hB -> state SKID, in_ready=0, out_alu=A; raise out_ready -> A then B delivered in order; in_ready returns to 1 one cycle after A drains.
- Flush in SKID with in_valid=1 -> next cycle out_valid=0, all control outputs 0, in_ready=1; no beat delivered afterwards.
- Async reset pulsed mid-cycle while FULL -> outputs zero immediately, without waiting for a clock edge; after release, behaviour as post-reset.
- With EX_MEM_STALL_CNT_EN defined: hold out_ready=0 for 5 cycles with a valid beat -> stall_cnt=5; flush -> stall_cnt still 5; reset -> 0.
